// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions, hazard FSM
// state and the source-register usage decode also used by the forwarding unit.
package pipeline_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MDU_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } src_use_t;

    // Which source register fields carry a real operand for this opcode.
    function automatic src_use_t decode_src_use(input logic [6:0] opcode);
        src_use_t u;
        u.rs1 = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
        u.rs2 = (opcode == OP || opcode == STORE || opcode == BRANCH);
        return u;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The datapath drives instructions/status every cycle; the controller answers
// combinationally in the same cycle (no valid/ready handshake, always valid).
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    import pipeline_pkg::*;

    logic [31:0]      instruction_in_decode;
    logic [31:0]      instruction_in_execution;
    logic             branch_taken_ex;
    logic             mdu_busy;
    logic             pc_write_enable;
    logic             if_id_write_enable;
    logic             if_id_flush;
    logic             id_ex_write_enable;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             mdu_timeout_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    hz_state_t        dbg_state;

    modport master (
        output instruction_in_decode, instruction_in_execution, branch_taken_ex, mdu_busy,
        input  pc_write_enable, if_id_write_enable, if_id_flush, id_ex_write_enable,
        input  id_ex_bubble, ex_mem_bubble, mdu_timeout_error, stall_cycles, flush_events,
        input  dbg_state
    );

    modport slave (
        input  instruction_in_decode, instruction_in_execution, branch_taken_ex, mdu_busy,
        output pc_write_enable, if_id_write_enable, if_id_flush, id_ex_write_enable,
        output id_ex_bubble, ex_mem_bubble, mdu_timeout_error, stall_cycles, flush_events,
        output dbg_state
    );

endinterface

// File: rtl/pipeline_hazard_controller_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / multi-cycle-unit / taken-branch sequencing for the 5-stage pipeline.
// Control outputs are Mealy: decided from the current state and this cycle's inputs.
module pipeline_hazard_controller #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MDU_TIMEOUT     = 64,
    parameter int CNT_W           = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);
    import pipeline_pkg::*;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] WD_LIMIT  = 8'(MDU_TIMEOUT);
    localparam bit         LU_MULTI  = (LU_STALL_CYCLES > 1);

    logic [6:0] opc_d;
    logic [6:0] opc_ex;
    logic [4:0] rd_ex;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    src_use_t   use_d;
    logic       lu_hit;
    logic       unused_instr_bits;

    assign opc_d  = bus.instruction_in_decode[OPCODE_MSB:OPCODE_LSB];
    assign rs1_d  = bus.instruction_in_decode[RS1_MSB:RS1_LSB];
    assign rs2_d  = bus.instruction_in_decode[RS2_MSB:RS2_LSB];
    assign opc_ex = bus.instruction_in_execution[OPCODE_MSB:OPCODE_LSB];
    assign rd_ex  = bus.instruction_in_execution[RD_MSB:RD_LSB];
    assign use_d  = decode_src_use(opc_d);

    assign unused_instr_bits = ^{bus.instruction_in_decode[31:25],
                                 bus.instruction_in_decode[14:7],
                                 bus.instruction_in_execution[31:12]};

    assign lu_hit = (opc_ex == LOAD) && (rd_ex != 5'd0) &&
                    ((use_d.rs1 && (rs1_d == rd_ex)) || (use_d.rs2 && (rs2_d == rd_ex)));

    hz_state_t  state_q, state_d;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wd_q, wd_d;
    logic [7:0] wd_inc;
    logic       err_q, err_d;
    logic       ign_q, ign_d;

    // Once MDU_WAIT has ended (finished or not), the cycle is judged like RUN.
    logic run_like;
    logic mdu_req;
    logic do_flush;
    logic do_mdu;
    logic do_lu;

    assign wd_inc   = wd_q + 8'd1;
    assign run_like = (state_q == ST_RUN) || ((state_q == ST_MDU_WAIT) && !bus.mdu_busy);
    assign mdu_req  = (state_q == ST_RUN) ? (bus.mdu_busy && !ign_q)
                                          : ((state_q == ST_MDU_WAIT) && bus.mdu_busy);
    assign do_flush = run_like && bus.branch_taken_ex;
    assign do_mdu   = !do_flush && mdu_req;
    assign do_lu    = (state_q == ST_LU_STALL) ||
                      (run_like && !bus.branch_taken_ex && !do_mdu && lu_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            lu_cnt_q <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            ign_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            ign_q    <= ign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        wd_d     = wd_q;
        err_d    = err_q;
        ign_d    = ign_q;
        if (!bus.mdu_busy) begin
            ign_d = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                if (do_mdu) begin
                    state_d = ST_MDU_WAIT;
                    wd_d    = 8'd1;
                end else if (do_lu && LU_MULTI) begin
                    state_d  = ST_LU_STALL;
                    lu_cnt_d = LU_RELOAD;
                end
            end
            ST_LU_STALL: begin
                lu_cnt_d = lu_cnt_q - 3'd1;
                if (lu_cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_MDU_WAIT: begin
                if (bus.mdu_busy) begin
                    wd_d = wd_inc;
                    // Watchdog expiry: give up on the unit and ignore busy until it drops.
                    if (wd_inc >= WD_LIMIT) begin
                        err_d   = 1'b1;
                        ign_d   = 1'b1;
                        wd_d    = '0;
                        state_d = ST_RUN;
                    end
                end else begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                    if (do_lu && LU_MULTI) begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_RELOAD;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    logic pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_bub, ex_mem_bub;

    always_comb begin
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        if_id_fl   = 1'b0;
        id_ex_we   = 1'b1;
        id_ex_bub  = 1'b0;
        ex_mem_bub = 1'b0;
        if (reset) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_we = 1'b0;
        end else if (do_flush) begin
            if_id_fl  = 1'b1;
            id_ex_bub = 1'b1;
        end else if (do_mdu) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_bub = 1'b1;
        end else if (do_lu) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_bub = 1'b1;
        end
    end

    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign stall_inc = !reset && (do_mdu || do_lu);
    assign flush_inc = !reset && do_flush;

    saturating_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .clear_i (1'b0),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    saturating_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .clear_i (1'b0),
        .inc_i   (flush_inc),
        .count_o (flush_cnt)
    );

    assign bus.pc_write_enable    = pc_we;
    assign bus.if_id_write_enable = if_id_we;
    assign bus.if_id_flush        = if_id_fl;
    assign bus.id_ex_write_enable = id_ex_we;
    assign bus.id_ex_bubble       = id_ex_bub;
    assign bus.ex_mem_bubble      = ex_mem_bub;
    assign bus.mdu_timeout_error  = err_q;
    assign bus.stall_cycles       = stall_cnt;
    assign bus.flush_events       = flush_cnt;
    assign bus.dbg_state          = state_q;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the 5-stage pipeline, next to the forwarding logic unit. Detects load-use hazards that forwarding cannot cover, freezes the front end while the multi-cycle multiply/divide unit occupies EX, and flushes wrong-path instructions on a taken branch or jump resolved in EX. Drives the PC, IF/ID, ID/EX and EX/MEM register enables and bubble controls. Keeps saturating performance counters.

## Interface
Parameters:
- LU_STALL_CYCLES, 1, stall cycles per load-use hazard (range 1..7)
- MDU_TIMEOUT, 64, maximum cycles `mdu_busy` may stay high (range 2..255)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- instruction_in_decode  in  32  instruction in the IF/ID register
- instruction_in_execution  in  32  instruction in the ID/EX register
- branch_taken_ex  in  1  taken branch or jump resolved in EX this cycle
- mdu_busy  in  1  multi-cycle unit in EX has not finished
- pc_write_enable  out  1  PC register load enable
- if_id_write_enable  out  1  IF/ID load enable
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_write_enable  out  1  ID/EX load enable
- id_ex_bubble  out  1  load a NOP into ID/EX
- ex_mem_bubble  out  1  load a NOP into EX/MEM
- mdu_timeout_error  out  1  sticky flag; the MDU watchdog expired
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_events  out  CNT_W  saturating count of flushes

## Operation
- Field extraction from the instructions:
  - opcode: [6:0]
  - rd: [11:7]
  - rs1: [19:15]
  - rs2: [24:20]
- Load in EX: opcode is 0000011.
- rs1 is used by the decode instruction for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- rs2 is used only by R-type 0110011, store 0100011 and branch 1100011.
- Hazard condition `lu_hit`: there is a load in EX, rd_EX != 0, and (rs1 is used and rs1_D == rd_EX) or (rs2 is used and rs2_D == rd_EX).
- States are RUN, LU_STALL and MDU_WAIT.
- RUN, priority highest first:
  1. branch_taken_ex:
     - pc_write_enable = 1, if_id_flush = 1, id_ex_bubble = 1.
     - flush_events increments.
     - State stays RUN. Any lu_hit in this cycle is ignored.
  2. mdu_busy:
     - pc_write_enable = 0, if_id_write_enable = 0, id_ex_write_enable = 0, ex_mem_bubble = 1.
     - Go to MDU_WAIT with watchdog = 1.
  3. lu_hit:
     - pc_write_enable = 0, if_id_write_enable = 0, id_ex_bubble = 1.
     - If LU_STALL_CYCLES > 1, go to LU_STALL with the remaining count = LU_STALL_CYCLES-1.
  4. Otherwise: all write enables are 1, all bubbles and the flush are 0.
- LU_STALL:
  - Outputs are the same as a RUN lu_hit cycle. The count decrements each cycle.
  - When the count reaches 1 in this cycle, return to RUN.
  - branch_taken_ex and mdu_busy cannot occur in this state (EX holds a bubble) and are ignored.
- MDU_WAIT:
  - Outputs are the same as RUN case 2 while mdu_busy = 1. The watchdog increments.
  - When mdu_busy = 0, the cycle behaves as RUN with no mdu case; the state returns to RUN in that same cycle.
  - When the watchdog reaches MDU_TIMEOUT while busy, set mdu_timeout_error and force a return to RUN. mdu_busy is then ignored until it deasserts.
- stall_cycles increments in every cycle in which pc_write_enable = 0.
- Both counters saturate at all-ones.

## Timing
- Outputs are Mealy: combinational from the state and the current inputs, with zero-cycle latency.
- The state, counters, watchdog and error flag are registered on the rising edge of clk.
- Reset is asynchronous and takes effect immediately:
  - state = RUN, counters = 0, watchdog = 0, mdu_timeout_error = 0.
  - All write enables = 0 and all bubbles/flush = 0 while reset is high.
- When reset is released, outputs follow the RUN rules from the first edge onward.
- A reset in the middle of a stall aborts the stall; no state is remembered.
- A load-use stall of N cycles delays the consumer by exactly N cycles.
- mdu_timeout_error is cleared only by reset.

## Structure
- The shared package `pipeline_pkg` holds:
  - the opcode constants (LOAD, STORE, OP, BRANCH, LUI, AUIPC, JAL)
  - the state enum
  - the field bit-slice localparams
- One sub-module, `saturating_counter` (parameter width, inc, clear), is instantiated twice.
- The rs1/rs2 usage decode is a function in the package, shared with the forwarding logic.

## Test plan
- Load-use: EX = 0x0000A283 (lw x5,0(x1)), decode = 0x00728333 (add x6,x5,x7) -> one cycle with pc_write_enable = 0, id_ex_bubble = 1; the next cycle is normal; stall_cycles = 1.
- x0 destination: EX = 0x0000A003 (lw x0), same decode -> no stall.
- Unused field: EX = 0x0000A283, decode = 0x000284B7 (lui x9 with [19:15] = 5) -> no stall.
- With LU_STALL_CYCLES = 3, the load-use pair -> stall for exactly 3 cycles, visiting LU_STALL for 2 of them.
- MDU: mdu_busy high for 3 cycles -> ex_mem_bubble = 1 and front-end enables = 0 for 3 cycles, then RUN.
- MDU timeout: with MDU_TIMEOUT = 4, mdu_busy held high -> error set after 4 cycles and remains set.
- Branch: branch_taken_ex while decode holds the load-use consumer -> if_id_flush = 1, id_ex_bubble = 1, pc_write_enable = 1, no stall, flush_events += 1.
- Saturation: with CNT_W = 2, 5 taken branches -> flush_events = 3.
